// File: rtl/reg_file_sb_if.sv
// Register-file scoreboard bus: read ports, two write ports, issue request
// and hazard status, seen from the register file as the slave side.
interface reg_file_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    a1_i;
  logic [AW-1:0]    a2_i;
  logic             re1_i;
  logic             re2_i;
  logic [WIDTH-1:0] rd1_o;
  logic [WIDTH-1:0] rd2_o;
  logic             we3_i;
  logic [AW-1:0]    a3_i;
  logic [WIDTH-1:0] wd3_i;
  logic             we4_i;
  logic [AW-1:0]    a4_i;
  logic [WIDTH-1:0] wd4_i;
  logic             issue_i;
  logic [AW-1:0]    issue_a_i;
  logic             stall_o;
  logic [AW:0]      busy_cnt_o;

  modport master (
    output a1_i, a2_i, re1_i, re2_i, we3_i, a3_i, wd3_i,
           we4_i, a4_i, wd4_i, issue_i, issue_a_i,
    input  rd1_o, rd2_o, stall_o, busy_cnt_o
  );

  modport slave (
    input  a1_i, a2_i, re1_i, re2_i, we3_i, a3_i, wd3_i,
           we4_i, a4_i, wd4_i, issue_i, issue_a_i,
    output rd1_o, rd2_o, stall_o, busy_cnt_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with write bypass and a per-register
// busy scoreboard that stalls RAW and WAW hazards against in-flight results.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             hz1_s;
  logic             hz2_s;
  logic             hz_iss_s;
  logic             stall_s;
  logic             accept_s;
  logic             dec3_s;
  logic             dec4_s;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == {AW{1'b0}});
  endfunction

  function automatic logic written(input logic [AW-1:0] a,
                                   input logic we3, input logic [AW-1:0] a3,
                                   input logic we4, input logic [AW-1:0] a4);
    return (we3 && (a3 == a)) || (we4 && (a4 == a));
  endfunction

  // Port 3 bypass beats port 4, and the hardwired zero register beats both.
  function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0] a,
                                              input logic [WIDTH-1:0] arr,
                                              input logic we3, input logic [AW-1:0] a3,
                                              input logic [WIDTH-1:0] wd3,
                                              input logic we4, input logic [AW-1:0] a4,
                                              input logic [WIDTH-1:0] wd4);
    if (is_zero(a))                return {WIDTH{1'b0}};
    else if (we3 && (a3 == a))     return wd3;
    else if (we4 && (a4 == a))     return wd4;
    else                           return arr;
  endfunction

  // Read data, hazard detection and issue acceptance.
  always_comb begin
    bus.rd1_o = rd_mux(bus.a1_i, mem_q[bus.a1_i], bus.we3_i, bus.a3_i, bus.wd3_i,
                       bus.we4_i, bus.a4_i, bus.wd4_i);
    bus.rd2_o = rd_mux(bus.a2_i, mem_q[bus.a2_i], bus.we3_i, bus.a3_i, bus.wd3_i,
                       bus.we4_i, bus.a4_i, bus.wd4_i);
    hz1_s     = bus.re1_i && busy_q[bus.a1_i] &&
                !written(bus.a1_i, bus.we3_i, bus.a3_i, bus.we4_i, bus.a4_i);
    hz2_s     = bus.re2_i && busy_q[bus.a2_i] &&
                !written(bus.a2_i, bus.we3_i, bus.a3_i, bus.we4_i, bus.a4_i);
    hz_iss_s  = bus.issue_i && busy_q[bus.issue_a_i] &&
                !written(bus.issue_a_i, bus.we3_i, bus.a3_i, bus.we4_i, bus.a4_i);
    stall_s   = hz1_s || hz2_s || hz_iss_s;
    accept_s  = bus.issue_i && !stall_s && !is_zero(bus.issue_a_i);
    bus.stall_o    = stall_s;
    bus.busy_cnt_o = busy_cnt_q;
  end

  // Next-state for data, busy bits and the busy population count.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (bus.we4_i && !is_zero(bus.a4_i)) begin
      mem_d[bus.a4_i]  = bus.wd4_i;
      busy_d[bus.a4_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bus.we3_i && !is_zero(bus.a3_i)) begin
      mem_d[bus.a3_i]  = bus.wd3_i;
      busy_d[bus.a3_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept_s) begin
      busy_d[bus.issue_a_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    // Port 4 only counts a release when port 3 is not releasing the same entry.
    dec3_s     = bus.we3_i && busy_q[bus.a3_i];
    dec4_s     = bus.we4_i && busy_q[bus.a4_i] && !(bus.we3_i && (bus.a3_i == bus.a4_i));
    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, accept_s}
                            - {{AW{1'b0}}, dec3_s}
                            - {{AW{1'b0}}, dec4_s};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      busy_q     <= {DEPTH{1'b0}};
      busy_cnt_q <= {(AW+1){1'b0}};
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus pushes expected values into a
// scoreboard queue, a monitor compares them on the falling edge.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  reg_file_sb_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_STL = 2;
  localparam int S_CNT = 3;

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic idle();
    bus.a1_i = 5'd0;  bus.a2_i = 5'd0;  bus.re1_i = 1'b0; bus.re2_i = 1'b0;
    bus.we3_i = 1'b0; bus.a3_i = 5'd0;  bus.wd3_i = 32'd0;
    bus.we4_i = 1'b0; bus.a4_i = 5'd0;  bus.wd4_i = 32'd0;
    bus.issue_i = 1'b0; bus.issue_a_i = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        case (e.sel)
          S_RD1:   act = bus.rd1_o;
          S_RD2:   act = bus.rd2_o;
          S_STL:   act = {31'd0, bus.stall_o};
          default: act = {26'd0, bus.busy_cnt_o};
        endcase
        n_checks++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", e.tag, act, e.val, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    step();
    bus.a1_i = 5'd3;
    push_exp("reset_rd1", S_RD1, 32'd0);
    push_exp("reset_cnt", S_CNT, 32'd0);
    push_exp("reset_stall", S_STL, 32'd0);

    // Same-cycle write bypass, then the stored value.
    step(); rst_n = 1'b1;
    bus.we3_i = 1'b1; bus.a3_i = 5'd5; bus.wd3_i = 32'hDEADBEEF; bus.a1_i = 5'd5;
    push_exp("bypass_wd3", S_RD1, 32'hDEADBEEF);
    #1;
    n_checks++;
    if (bus.rd1_o === 32'hDEADBEEF) n_pass++;
    else $display("FAIL direct_bypass_wd3: got %h, expected %h", bus.rd1_o, 32'hDEADBEEF);
    step(); bus.a1_i = 5'd5;
    push_exp("stored_r5", S_RD1, 32'hDEADBEEF);

    // Port 3 wins on a same-address double write.
    step();
    bus.we3_i = 1'b1; bus.a3_i = 5'd7; bus.wd3_i = 32'h11;
    bus.we4_i = 1'b1; bus.a4_i = 5'd7; bus.wd4_i = 32'h22;
    bus.a1_i = 5'd7; bus.a2_i = 5'd7;
    push_exp("dual_wr_rd1", S_RD1, 32'h11);
    push_exp("dual_wr_rd2", S_RD2, 32'h11);
    step(); bus.a1_i = 5'd7;
    push_exp("dual_wr_stored", S_RD1, 32'h11);

    // Zero register ignores writes and issues.
    step();
    bus.we3_i = 1'b1; bus.a3_i = 5'd0; bus.wd3_i = 32'hFF; bus.a1_i = 5'd0;
    push_exp("zero_bypass", S_RD1, 32'd0);
    step(); bus.a1_i = 5'd0; bus.issue_i = 1'b1; bus.issue_a_i = 5'd0;
    push_exp("zero_stored", S_RD1, 32'd0);
    push_exp("zero_issue_stall", S_STL, 32'd0);
    step(); bus.re1_i = 1'b1; bus.a1_i = 5'd0;
    push_exp("zero_issue_cnt", S_CNT, 32'd0);
    push_exp("zero_re_stall", S_STL, 32'd0);

    // RAW hazard on r9 resolved by a late load return.
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd9;
    push_exp("iss9_stall", S_STL, 32'd0);
    step(); bus.re1_i = 1'b1; bus.a1_i = 5'd9;
    push_exp("iss9_cnt", S_CNT, 32'd1);
    push_exp("raw9_stall", S_STL, 32'd1);
    step(); bus.re1_i = 1'b1; bus.a1_i = 5'd9;
    bus.we4_i = 1'b1; bus.a4_i = 5'd9; bus.wd4_i = 32'hCAFE0009;
    push_exp("raw9_wr_stall", S_STL, 32'd0);
    push_exp("raw9_wr_rd1", S_RD1, 32'hCAFE0009);
    push_exp("raw9_wr_cnt", S_CNT, 32'd1);
    step(); bus.a1_i = 5'd9;
    push_exp("r9_release_cnt", S_CNT, 32'd0);
    push_exp("r9_stored", S_RD1, 32'hCAFE0009);

    // WAW on r4: stalled without a write, accepted alongside one.
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd4;
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd4;
    push_exp("waw4_stall", S_STL, 32'd1);
    push_exp("waw4_cnt", S_CNT, 32'd1);
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd4;
    bus.we3_i = 1'b1; bus.a3_i = 5'd4; bus.wd3_i = 32'h44;
    push_exp("waw4_held_cnt", S_CNT, 32'd1);
    push_exp("waw4_wr_stall", S_STL, 32'd0);
    step(); bus.re2_i = 1'b1; bus.a2_i = 5'd4;
    push_exp("r4_still_busy", S_STL, 32'd1);
    push_exp("r4_issue_wins_cnt", S_CNT, 32'd1);
    step(); bus.re2_i = 1'b1; bus.a2_i = 5'd4;
    bus.we4_i = 1'b1; bus.a4_i = 5'd4; bus.wd4_i = 32'h4444;
    push_exp("r4_wr4_stall", S_STL, 32'd0);
    push_exp("r4_wr4_rd2", S_RD2, 32'h4444);
    step(); bus.a2_i = 5'd4;
    push_exp("r4_release_cnt", S_CNT, 32'd0);
    push_exp("r4_stored", S_RD2, 32'h4444);

    // Two releases in one cycle.
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd10;
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd11;
    push_exp("cnt_after_r10", S_CNT, 32'd1);
    step();
    bus.we3_i = 1'b1; bus.a3_i = 5'd10; bus.wd3_i = 32'hA;
    bus.we4_i = 1'b1; bus.a4_i = 5'd11; bus.wd4_i = 32'hB;
    bus.a1_i = 5'd10; bus.a2_i = 5'd11;
    push_exp("cnt_two_busy", S_CNT, 32'd2);
    push_exp("r10_bypass", S_RD1, 32'hA);
    push_exp("r11_bypass", S_RD2, 32'hB);
    step();
    push_exp("cnt_minus2", S_CNT, 32'd0);

    // Mid-operation reset clears everything between edges.
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd1;
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd2;
    step(); bus.issue_i = 1'b1; bus.issue_a_i = 5'd3;
    step(); bus.re1_i = 1'b1; bus.a1_i = 5'd1;
    push_exp("cnt_three", S_CNT, 32'd3);
    push_exp("raw1_stall", S_STL, 32'd1);
    #1;
    n_checks++;
    if (bus.busy_cnt_o === 6'd3) n_pass++;
    else $display("FAIL direct_cnt_three: got %h, expected %h", bus.busy_cnt_o, 6'd3);
    step(); rst_n = 1'b0;
    bus.re1_i = 1'b1; bus.a1_i = 5'd5; bus.re2_i = 1'b1; bus.a2_i = 5'd1;
    bus.issue_i = 1'b1; bus.issue_a_i = 5'd6;
    push_exp("rst_mid_cnt", S_CNT, 32'd0);
    push_exp("rst_mid_stall", S_STL, 32'd0);
    push_exp("rst_mid_rd1", S_RD1, 32'd0);
    push_exp("rst_mid_rd2", S_RD2, 32'd0);
    #1;
    n_checks++;
    if (bus.busy_cnt_o === 6'd0) n_pass++;
    else $display("FAIL direct_rst_mid_cnt: got %h, expected %h", bus.busy_cnt_o, 6'd0);
    n_checks++;
    if (bus.stall_o === 1'b0) n_pass++;
    else $display("FAIL direct_rst_mid_stall: got %b, expected %b", bus.stall_o, 1'b0);
    step(); rst_n = 1'b0; bus.issue_i = 1'b1; bus.issue_a_i = 5'd6;
    step(); rst_n = 1'b1; bus.a1_i = 5'd7; bus.re2_i = 1'b1; bus.a2_i = 5'd6;
    push_exp("post_rst_cnt", S_CNT, 32'd0);
    push_exp("post_rst_rd1", S_RD1, 32'd0);
    push_exp("post_rst_r6_idle", S_STL, 32'd0);
    bus.issue_i = 1'b1; bus.issue_a_i = 5'd12;
    #1;
    n_checks++;
    if (bus.busy_cnt_o === 6'd0) n_pass++;
    else $display("FAIL direct_post_rst_cnt: got %h, expected %h", bus.busy_cnt_o, 6'd0);
    step();
    push_exp("post_rst_issue_cnt", S_CNT, 32'd1);

    step();
    step();
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_checks++;
      $display("FAIL %s: never compared, expected %h", e.tag, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
